zet_pic: RTL and testbench
==========================

Name: zet_pic

Overview:
- Interrupt controller, 8259-lite; the responding end of the CPU interrupt-acknowledge handshake (wb_tgc_o/inta, wb_tgc_i/intr).
- Collects up to 8 edge-triggered IRQ lines and arbitrates them by fixed priority (IRQ0 highest).
- Raises intr to the CPU and returns the vector number during inta.
- Programmed through a 16-bit Wishbone I/O slave: mask, vector base, EOI.

Parameters:
- NIRQ, 8, number of IRQ inputs (1..8); unused upper bits read 0 and are never requested.
- BASE_RST, 8'h08, vector base after reset (IRQk -> BASE+k).

Ports:
- wb_clk_i  in  1  system clock.
- wb_rst_n_i  in  1  reset, asynchronous assert, active-low.
- wb_dat_i  in  16  write data.
- wb_dat_o  out  16  read data.
- wb_adr_i  in  1  register select (I/O address bit 1).
- wb_we_i  in  1  write enable.
- wb_stb_i  in  1  strobe.
- wb_cyc_i  in  1  cycle.
- wb_ack_o  out  1  acknowledge.
- irq_i  in  NIRQ  asynchronous interrupt requests, rising-edge sensitive.
- intr_o  out  1  interrupt request to CPU (wb_tgc_i).
- inta_i  in  1  acknowledge level from CPU (wb_tgc_o).
- vec_o  out  16  {8'h00, vector}; top muxes it onto CPU dat_i while inta is high.

Behaviour:
- Reset: IRR=0, ISR=0, IMR=8'hFF, BASE=BASE_RST, intr_o=0, vec_o=0, wb_ack_o=0, wb_dat_o=0, state=IDLE, synchronisers=0.
- Input path: irq_i passes through a 2-flop synchroniser, then a third flop for edge detection. A 0->1 edge sets IRR[k]. Minimum latency from irq_i rising to IRR set is 3 clocks.
- Pending vector: P = IRR & ~IMR. Winner w = lowest set bit of P. Highest in-service s = lowest set bit of ISR.
- Request condition: P != 0, and (ISR == 0 or w < s). This gives fully nested operation.
- FSM IDLE: request condition true -> REQ, intr_o <= 1 (registered, one clock after the condition).
- FSM REQ: condition lost before inta (mask write, etc.) -> IDLE, intr_o <= 0. inta_i rising (inta_i & ~inta_q) -> ACK.
- On entering ACK:
  - Winner valid: vec_o <= BASE+w, IRR[w] <= 0, ISR[w] <= 1.
  - Winner invalid (spurious): vec_o <= BASE+7, IRR and ISR unchanged.
  - In both cases intr_o <= 0.
- FSM ACK: vec_o held stable while inta_i=1. inta_i falls -> IDLE. vec_o keeps its value until the next ACK.
- inta_i rising while in IDLE: treated as spurious (vector BASE+7), goes to ACK.
- Same-cycle edge on IRR[k] and acknowledge of k: the set wins, so IRR[k] stays 1.
- Wishbone slave:
  - ack = registered stb&cyc&~ack. Exactly one ack per access, 1-cycle latency, never back-to-back within one strobe.
  - Register effects commit on the clock where ack is asserted.
- Register map, adr 0:
  - Write with dat[5]=1: non-specific EOI, clears ISR[s] (no-op if ISR=0).
  - Write with dat[5]=0: ignored.
  - Read returns {ISR, IRR}.
- Register map, adr 1:
  - Write: IMR <= dat[7:0]; BASE <= {dat[15:11], 3'b000}.
  - Read returns {BASE, IMR}.
- Simultaneous EOI write and ACK entry: EOI uses the pre-cycle ISR, then ISR[w] is set. Both take effect.
- Mask write while in REQ: re-evaluated the next clock; intr_o may drop without an acknowledge.
- Width rules: vector add is 8-bit, no carry out (BASE low 3 bits are always 0). Bits >= NIRQ of IRR/ISR/IMR are forced 0, except that IMR reads back as written.
- Reset mid-operation: all state returns asynchronously to reset values; intr_o drops immediately.

Decomposition:
- Shared package zet_pic_pkg:
  - Register offsets: PIC_ADR_CMD=0, PIC_ADR_MASK=1.
  - EOI_BIT=5, SPURIOUS_IRQ=7.
  - FSM state encoding IDLE/REQ/ACK.
- Sub-module zet_pic_prio: combinational lowest-set-bit finder returning {valid, index[2:0]}. Instantiated twice, for P and ISR.

Test Plan:
- Reset, then read adr1 -> 16'h08FF; read adr0 -> 16'h0000; intr_o=0.
- Write adr1=16'h0800 (unmask all), pulse irq_i[3] -> intr_o=1 within 4 clocks; raise inta_i -> vec_o=16'h000B, intr_o=0, adr0 reads 16'h0800; drop inta_i.
- Pulse irq_i[5] and irq_i[2] in the same clock -> first inta gives vec 16'h000A. EOI write adr0=16'h0020 -> ISR=0, intr re-asserts. Second inta gives 16'h000D.
- Nesting: IRQ4 in service (ISR=8'h10). Pulse irq5 -> intr stays 0. Pulse irq1 -> intr=1, inta vec 16'h0009, ISR=8'h12. EOI clears bit1 only, leaving ISR=8'h10.
- Spurious: irq6 pending, intr=1. Write IMR=8'h40 then assert inta -> vec_o=16'h000F, ISR unchanged, IRR[6]=1.
- Base change and reset: write adr1=16'h7000, ack irq0 -> vec 16'h0070. Assert wb_rst_n_i low mid-inta -> intr_o=0 and adr1 reads 16'h08FF after release.

Source files
------------

// File: rtl/zet_pic_pkg.sv
// Shared definitions for the zet_pic interrupt controller.
//   - Wishbone register offsets (one address bit)
//   - command-register EOI bit position and the spurious IRQ index
//   - acknowledge FSM state encoding
package zet_pic_pkg;

    localparam logic       PIC_ADR_CMD  = 1'b0;
    localparam logic       PIC_ADR_MASK = 1'b1;

    localparam int         EOI_BIT      = 5;
    localparam logic [2:0] SPURIOUS_IRQ = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        ACK  = 2'd2
    } pic_state_t;

endpackage

// File: rtl/zet_pic_if.sv
// Wishbone I/O slave bus of the interrupt controller.
//   wb_dat_i/wb_dat_o : 16-bit write/read data
//   wb_adr_i          : register select (I/O address bit 1)
//   wb_we_i, wb_stb_i, wb_cyc_i : write enable, strobe, cycle
//   wb_ack_o          : single-cycle acknowledge
// master = CPU side, slave = controller side.
interface zet_pic_if;
    logic [15:0] wb_dat_i;
    logic [15:0] wb_dat_o;
    logic        wb_adr_i;
    logic        wb_we_i;
    logic        wb_stb_i;
    logic        wb_cyc_i;
    logic        wb_ack_o;

    modport master (
        output wb_dat_i, wb_adr_i, wb_we_i, wb_stb_i, wb_cyc_i,
        input  wb_dat_o, wb_ack_o
    );

    modport slave (
        input  wb_dat_i, wb_adr_i, wb_we_i, wb_stb_i, wb_cyc_i,
        output wb_dat_o, wb_ack_o
    );
endinterface

// File: rtl/zet_pic_prio.sv
// Lowest-set-bit finder used for fixed-priority arbitration (bit 0 wins).
//   bits  : 8-bit request vector
//   valid : at least one bit set
//   idx   : index of the lowest set bit (0 when none set)
module zet_pic_prio (
    input  logic [7:0] bits,
    output logic       valid,
    output logic [2:0] idx
);
    always_comb begin
        valid = |bits;
        idx   = 3'd0;
        // Scan downwards so the lowest set bit is the last one written.
        for (int i = 7; i >= 0; i--) begin
            if (bits[i]) idx = 3'(i);
        end
    end
endmodule

// File: rtl/zet_pic.sv
// zet_pic: 8259-style interrupt controller with fixed priority (IRQ0 highest)
// and fully nested in-service handling.
//   wb_clk_i, wb_rst_n_i : clock, asynchronous active-low reset
//   wb                   : Wishbone I/O slave (mask/base at adr 1, EOI at adr 0)
//   irq_i                : asynchronous rising-edge interrupt requests
//   intr_o               : interrupt request to the CPU
//   inta_i               : acknowledge level from the CPU
//   vec_o                : {8'h00, vector}, stable while inta_i is high
module zet_pic
    import zet_pic_pkg::*;
#(
    parameter int         NIRQ     = 8,
    parameter logic [7:0] BASE_RST = 8'h08
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_n_i,
    zet_pic_if.slave         wb,
    input  logic [NIRQ-1:0]  irq_i,
    output logic             intr_o,
    input  logic             inta_i,
    output logic [15:0]      vec_o
);
    localparam logic [8:0] ONE_HOT  = 9'd1 << NIRQ;
    localparam logic [7:0] IRQ_MASK = 8'(ONE_HOT - 9'd1);

    logic [7:0] irq_pad;
    logic [7:0] sync1_reg, sync2_reg, sync3_reg;
    logic [7:0] irr_reg, isr_reg, imr_reg, base_reg;
    logic [7:0] irr_next, isr_next;
    logic       inta_q_reg, ack_reg, intr_reg;
    logic [15:0] dat_o_reg, vec_reg;
    pic_state_t state_reg;

    // Unused IRQ positions are tied low so they can never be requested.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_pad
            if (gi < NIRQ) begin : g_used
                assign irq_pad[gi] = irq_i[gi];
            end else begin : g_unused
                assign irq_pad[gi] = 1'b0;
            end
        end
    endgenerate

    logic [7:0] edge_det, pend;
    logic       w_valid, s_valid;
    logic [2:0] w_idx, s_idx;

    assign edge_det = sync2_reg & ~sync3_reg;
    assign pend     = irr_reg & ~imr_reg & IRQ_MASK;

    zet_pic_prio u_prio_pend (.bits(pend),    .valid(w_valid), .idx(w_idx));
    zet_pic_prio u_prio_isr  (.bits(isr_reg), .valid(s_valid), .idx(s_idx));

    // Only a strictly higher-priority request may interrupt the current service.
    logic req_cond;
    assign req_cond = w_valid && (!s_valid || (w_idx < s_idx));

    logic wb_fire, wr_mask, eoi, inta_rise, ack_valid;
    assign wb_fire   = wb.wb_stb_i & wb.wb_cyc_i & ~ack_reg;
    assign wr_mask   = wb_fire & wb.wb_we_i & (wb.wb_adr_i == PIC_ADR_MASK);
    assign eoi       = wb_fire & wb.wb_we_i & (wb.wb_adr_i == PIC_ADR_CMD)
                       & wb.wb_dat_i[EOI_BIT];
    assign inta_rise = inta_i & ~inta_q_reg;
    assign ack_valid = inta_rise && (state_reg == REQ) && w_valid;

    always_comb begin
        // EOI acts on the pre-cycle ISR; a concurrent acknowledge then sets its bit.
        isr_next = isr_reg;
        if (eoi && s_valid) isr_next[s_idx] = 1'b0;
        if (ack_valid)      isr_next[w_idx] = 1'b1;
        isr_next = isr_next & IRQ_MASK;

        // A new edge on the acknowledged line wins over the clear.
        irr_next = irr_reg;
        if (ack_valid) irr_next[w_idx] = 1'b0;
        irr_next = (irr_next | edge_det) & IRQ_MASK;
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            sync1_reg  <= '0;
            sync2_reg  <= '0;
            sync3_reg  <= '0;
            irr_reg    <= '0;
            isr_reg    <= '0;
            imr_reg    <= 8'hFF;
            base_reg   <= BASE_RST;
            inta_q_reg <= 1'b0;
            ack_reg    <= 1'b0;
            dat_o_reg  <= '0;
            intr_reg   <= 1'b0;
            vec_reg    <= '0;
            state_reg  <= IDLE;
        end else begin
            sync1_reg  <= irq_pad;
            sync2_reg  <= sync1_reg;
            sync3_reg  <= sync2_reg;
            inta_q_reg <= inta_i;
            irr_reg    <= irr_next;
            isr_reg    <= isr_next;

            ack_reg <= wb_fire;
            if (wb_fire) begin
                dat_o_reg <= (wb.wb_adr_i == PIC_ADR_MASK) ? {base_reg, imr_reg}
                                                           : {isr_reg, irr_reg};
            end
            if (wr_mask) begin
                imr_reg  <= wb.wb_dat_i[7:0];
                base_reg <= {wb.wb_dat_i[15:11], 3'b000};
            end

            case (state_reg)
                IDLE: begin
                    if (inta_rise) begin
                        state_reg <= ACK;
                        intr_reg  <= 1'b0;
                        vec_reg   <= {8'h00, base_reg + {5'b0, SPURIOUS_IRQ}};
                    end else if (req_cond) begin
                        state_reg <= REQ;
                        intr_reg  <= 1'b1;
                    end
                end
                REQ: begin
                    if (inta_rise) begin
                        state_reg <= ACK;
                        intr_reg  <= 1'b0;
                        vec_reg   <= {8'h00, base_reg +
                                      {5'b0, (w_valid ? w_idx : SPURIOUS_IRQ)}};
                    end else if (!req_cond) begin
                        state_reg <= IDLE;
                        intr_reg  <= 1'b0;
                    end
                end
                ACK: begin
                    if (!inta_i) state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                    intr_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign intr_o      = intr_reg;
    assign vec_o       = vec_reg;
    assign wb.wb_ack_o = ack_reg;
    assign wb.wb_dat_o = dat_o_reg;

endmodule

// File: tb/tb_zet_pic.sv
module tb_zet_pic;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  irq;
    logic        inta;
    logic        intr;
    logic [15:0] vec;
    logic [15:0] rd;
    int          n_pass = 0;
    int          n_total = 0;

    always #5 clk = ~clk;

    zet_pic_if bus ();

    zet_pic #(.NIRQ(8), .BASE_RST(8'h08)) dut (
        .wb_clk_i   (clk),
        .wb_rst_n_i (rst_n),
        .wb         (bus.slave),
        .irq_i      (irq),
        .intr_o     (intr),
        .inta_i     (inta),
        .vec_o      (vec)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wb_xfer(input logic adr, input logic we, input logic [15:0] dat,
                           output logic [15:0] data_rd);
        int k;
        @(posedge clk); #1;
        bus.wb_adr_i = adr;
        bus.wb_we_i  = we;
        bus.wb_dat_i = dat;
        bus.wb_stb_i = 1'b1;
        bus.wb_cyc_i = 1'b1;
        k = 0;
        do begin
            @(posedge clk); #1;
            k++;
        end while (bus.wb_ack_o !== 1'b1 && k < 8);
        chk("wb_ack", {15'b0, bus.wb_ack_o}, 16'h0001);
        data_rd = bus.wb_dat_o;
        bus.wb_stb_i = 1'b0;
        bus.wb_cyc_i = 1'b0;
        bus.wb_we_i  = 1'b0;
        $display("wb %s adr=%0d dat=%h", we ? "wr" : "rd", adr, we ? dat : data_rd);
    endtask

    task automatic wb_read(input string tag, input logic adr, input logic [15:0] exp);
        logic [15:0] d;
        wb_xfer(adr, 1'b0, 16'h0000, d);
        chk(tag, d, exp);
    endtask

    task automatic wb_write(input logic adr, input logic [15:0] dat);
        logic [15:0] d;
        wb_xfer(adr, 1'b1, dat, d);
    endtask

    task automatic pulse(input logic [7:0] m);
        @(posedge clk); #1;
        irq = irq | m;
        step(2);
        irq = irq & ~m;
        $display("irq pulse mask=%h", m);
    endtask

    task automatic wait_intr(input string tag);
        int k;
        k = 0;
        while (intr !== 1'b1 && k < 8) begin
            step(1);
            k++;
        end
        chk(tag, {15'b0, intr}, 16'h0001);
    endtask

    task automatic do_inta(input string tag, input logic [15:0] exp_vec);
        @(posedge clk); #1;
        inta = 1'b1;
        step(1);
        chk(tag, vec, exp_vec);
        chk({tag, "_intr"}, {15'b0, intr}, 16'h0000);
        $display("inta vec=%h", vec);
    endtask

    task automatic inta_off();
        @(posedge clk); #1;
        inta = 1'b0;
        step(2);
    endtask

    initial begin
        rst_n = 1'b0;
        irq   = '0;
        inta  = 1'b0;
        bus.wb_dat_i = '0;
        bus.wb_adr_i = 1'b0;
        bus.wb_we_i  = 1'b0;
        bus.wb_stb_i = 1'b0;
        bus.wb_cyc_i = 1'b0;
        step(3);
        chk("rst_intr", {15'b0, intr}, 16'h0000);
        chk("rst_vec", vec, 16'h0000);
        chk("rst_ack", {15'b0, bus.wb_ack_o}, 16'h0000);
        rst_n = 1'b1;
        step(1);
        wb_read("rst_adr1", 1'b1, 16'h08FF);
        wb_read("rst_adr0", 1'b0, 16'h0000);

        // Single IRQ3
        wb_write(1'b1, 16'h0800);
        pulse(8'h08);
        wait_intr("irq3_intr");
        do_inta("irq3_vec", 16'h000B);
        wb_read("irq3_isr", 1'b0, 16'h0800);
        inta_off();
        wb_write(1'b0, 16'h0020);
        wb_read("irq3_eoi", 1'b0, 16'h0000);

        // IRQ5 and IRQ2 together: 2 first, then 5 after EOI
        pulse(8'h24);
        wait_intr("dual_intr1");
        do_inta("dual_vec1", 16'h000A);
        inta_off();
        wb_write(1'b0, 16'h0020);
        wb_read("dual_eoi", 1'b0, 16'h0020);
        wait_intr("dual_intr2");
        do_inta("dual_vec2", 16'h000D);
        inta_off();
        wb_write(1'b0, 16'h0020);

        // Nesting with IRQ4 in service
        pulse(8'h10);
        wait_intr("nest_intr4");
        do_inta("nest_vec4", 16'h000C);
        inta_off();
        pulse(8'h20);
        step(6);
        chk("nest_lowpri_blocked", {15'b0, intr}, 16'h0000);
        pulse(8'h02);
        wait_intr("nest_intr1");
        do_inta("nest_vec1", 16'h0009);
        wb_read("nest_isr12", 1'b0, 16'h1220);
        inta_off();
        wb_write(1'b0, 16'h0020);
        wb_read("nest_eoi1", 1'b0, 16'h1020);
        wb_write(1'b0, 16'h0020);
        wait_intr("nest_intr5");
        do_inta("nest_vec5", 16'h000D);
        inta_off();
        wb_write(1'b0, 16'h0020);
        wb_read("nest_clear", 1'b0, 16'h0000);

        // Spurious: IRQ6 masked away before the acknowledge
        pulse(8'h40);
        wait_intr("spur_intr");
        wb_write(1'b1, 16'h0840);
        step(1);
        chk("spur_intr_drop", {15'b0, intr}, 16'h0000);
        do_inta("spur_vec", 16'h000F);
        wb_read("spur_regs", 1'b0, 16'h0040);
        inta_off();
        wb_write(1'b1, 16'h0800);
        wait_intr("spur_unmask_intr");
        do_inta("spur_unmask_vec", 16'h000E);
        inta_off();
        wb_write(1'b0, 16'h0020);

        // Base change, then reset during acknowledge
        wb_write(1'b1, 16'h7000);
        wb_read("base_regs", 1'b1, 16'h7000);
        pulse(8'h01);
        wait_intr("base_intr");
        do_inta("base_vec", 16'h0070);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_intr", {15'b0, intr}, 16'h0000);
        chk("rst_mid_vec", vec, 16'h0000);
        inta = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(1);
        wb_read("rst_mid_adr1", 1'b1, 16'h08FF);
        wb_read("rst_mid_adr0", 1'b0, 16'h0000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
